// File: rtl/imem_fetch_pkg.sv
// rtl/imem_fetch_pkg.sv - shared state encoding and constants for the byte-wide instruction fetch bridge
package imem_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_ADDR,
    RECV,
    DONE,
    ERR
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // Counter width needed to walk n_bytes address bytes
  function automatic int unsigned byte_cnt_width(input int unsigned n_bytes);
    return $clog2(n_bytes) + 1;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - saturating idle-cycle counter with an expiry flag
module fetch_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_Q = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;

  assign expired = (count == LIMIT_Q);

  // Count idle cycles; clear has priority and the count holds once it reaches the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_byte_fetch.sv
// rtl/imem_byte_fetch.sv - word-PC instruction fetch over a byte-wide pin bus with a one-entry cache
module imem_byte_fetch
  import imem_fetch_pkg::*;
#(
  parameter int unsigned ADDR_BYTES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc_addr,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic        invalidate,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        busy,
  output logic        fetch_err,
  output logic [7:0]  ext_out_data,
  output logic        ext_out_valid,
  input  logic        ext_out_ready,
  input  logic [7:0]  ext_in_data,
  input  logic        ext_in_valid
);

  localparam int unsigned CNT_W = byte_cnt_width(ADDR_BYTES);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_BYTES - 1);

  fetch_state_e state, state_nxt;

  logic [31:0]      addr_q;
  logic [31:0]      cache_tag;
  logic [31:0]      cache_data;
  logic [31:0]      instr_buf;
  logic [31:0]      instr_nxt;
  logic             cache_vld;
  logic             flush_pend;
  logic             drop;
  logic             hit;
  logic             addr_last;
  logic             data_last;
  logic             expired;
  logic             timer_clear;
  logic             timer_inc;
  logic [CNT_W-1:0] addr_cnt;
  logic [1:0]       data_cnt;
  logic [7:0]       addr_byte;

  assign hit       = cache_vld && (pc_addr == cache_tag);
  assign addr_last = (addr_cnt == LAST_ADDR);
  assign data_last = (data_cnt == 2'd3);
  // A flush arriving in the completing cycle discards the result just like a pending one
  assign drop      = flush_pend || flush;

  assign ext_out_valid = (state == SEND_ADDR);
  assign ext_out_data  = ext_out_valid ? addr_byte : 8'h00;

  assign timer_inc   = (state == RECV) && !ext_in_valid;
  assign timer_clear = (state != RECV) || ext_in_valid;

  fetch_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (clr),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .expired (expired)
  );

  // Select the address byte on the pins, most significant byte first
  always_comb begin
    addr_byte = 8'h00;
    for (int i = 0; i < int'(ADDR_BYTES); i++) begin
      if (addr_cnt == CNT_W'(i)) begin
        addr_byte = addr_q[8*(int'(ADDR_BYTES)-1-i) +: 8];
      end
    end
  end

  // Merge the arriving instruction byte into the partial word, little-endian
  always_comb begin
    instr_nxt = instr_buf;
    instr_nxt[8*data_cnt +: 8] = ext_in_data;
  end

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; DONE and ERR are single-cycle dwell states
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fetch_req && !hit) state_nxt = SEND_ADDR;
      end
      SEND_ADDR: begin
        if (ext_out_ready && addr_last) state_nxt = RECV;
      end
      RECV: begin
        if (ext_in_valid) begin
          if (data_last) state_nxt = DONE;
        end else if (expired) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: cache, counters and core-facing outputs; results are registered on entry to DONE/ERR
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      fetch_err   <= 1'b0;
      cache_vld   <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
      addr_q      <= '0;
      instr_buf   <= '0;
      addr_cnt    <= '0;
      data_cnt    <= '0;
      flush_pend  <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      if (flush && busy) flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (fetch_req) begin
            if (hit) begin
              if (!flush) begin
                instr_valid <= 1'b1;
                instr_out   <= cache_data;
              end
            end else begin
              addr_q   <= pc_addr;
              busy     <= 1'b1;
              addr_cnt <= '0;
              data_cnt <= '0;
            end
          end
        end
        SEND_ADDR: begin
          if (ext_out_ready) begin
            addr_cnt <= addr_last ? '0 : addr_cnt + CNT_W'(1);
          end
        end
        RECV: begin
          if (ext_in_valid) begin
            instr_buf <= instr_nxt;
            data_cnt  <= data_cnt + 2'd1;
            if (data_last) begin
              cache_tag  <= addr_q;
              cache_data <= instr_nxt;
              cache_vld  <= 1'b1;
              if (!drop) begin
                instr_out   <= instr_nxt;
                instr_valid <= 1'b1;
              end
              busy       <= 1'b0;
              flush_pend <= 1'b0;
            end
          end else if (expired) begin
            instr_out   <= NOP_INSTR;
            instr_valid <= !drop;
            fetch_err   <= 1'b1;
            busy        <= 1'b0;
            flush_pend  <= 1'b0;
          end
        end
        default: ;
      endcase

      if (invalidate) cache_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_byte_fetch.sv
// tb/tb_imem_byte_fetch.sv - randomized self-checking bench for imem_byte_fetch
module tb_imem_byte_fetch;

  localparam int AB  = 2;
  localparam int TMO = 255;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] pc_addr;
  logic        fetch_req;
  logic        flush;
  logic        invalidate;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        busy;
  logic        fetch_err;
  logic [7:0]  ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic [7:0]  ext_in_data;
  logic        ext_in_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one-entry cache and the value the core currently sees
  logic        m_vld;
  logic [31:0] m_tag;
  logic [31:0] m_data;
  logic [31:0] m_out;

  imem_byte_fetch dut (
    .clk           (clk),
    .clr           (clr),
    .pc_addr       (pc_addr),
    .fetch_req     (fetch_req),
    .flush         (flush),
    .invalidate    (invalidate),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .busy          (busy),
    .fetch_err     (fetch_err),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One fetch transaction, acting as the core and the external memory; starts and ends at a negedge
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word,
                          input int ready_pct, input int first_stall, input int gap_max,
                          input int stop_after, input bit do_flush, input bit do_inv,
                          input bit chk_lat);
    bit          hit;
    bit          err;
    bit          flushed;
    int          idx, stall, cyc, n, idle, gap_left;
    logic [31:0] exp_out;

    hit       = m_vld && (m_tag == addr);
    pc_addr   = addr;
    fetch_req = 1'b1;
    flush     = hit && do_flush;
    @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    flush     = 1'b0;
    pc_addr   = $urandom;

    if (hit) begin
      exp_out = do_flush ? m_out : m_data;
      check("hit_valid", 32'(instr_valid), 32'(!do_flush));
      check("hit_data", instr_out, exp_out);
      check("hit_busy", 32'(busy), 0);
      check("hit_ext", 32'(ext_out_valid), 0);
      m_out = exp_out;
      @(posedge clk);
      @(negedge clk);
      check("hit_pulse", 32'(instr_valid), 0);
      check("hit_noext", 32'(ext_out_valid), 0);
      check("hit_nobusy", 32'(busy), 0);
      return;
    end

    cyc   = 1;
    idx   = 0;
    stall = 0;
    while (idx < AB) begin
      check("busy_addr", 32'(busy), 1);
      check("out_valid", 32'(ext_out_valid), 1);
      check("out_byte", 32'(ext_out_data), 32'(addr[8*(AB-1-idx) +: 8]));
      check("noval_addr", 32'(instr_valid), 0);
      if (idx == 0 && stall < first_stall) begin
        ext_out_ready = 1'b0;
        stall++;
      end else begin
        ext_out_ready = ($urandom_range(99) < ready_pct);
      end
      @(posedge clk);
      if (ext_out_ready) idx++;
      @(negedge clk);
      cyc++;
      if (cyc > 1000) begin
        check("addr_bound", 32'(cyc), 0);
        break;
      end
    end
    ext_out_ready = 1'b0;

    n        = 0;
    idle     = 0;
    flushed  = 1'b0;
    gap_left = $urandom_range(gap_max);
    while (n < 4 && idle <= TMO) begin
      check("busy_recv", 32'(busy), 1);
      check("noval_recv", 32'(instr_valid), 0);
      check("out_idle", 32'(ext_out_valid), 0);
      if (do_flush && !flushed) begin
        flush   = 1'b1;
        flushed = 1'b1;
      end
      if (n < stop_after && gap_left == 0) begin
        ext_in_valid = 1'b1;
        ext_in_data  = word[8*n +: 8];
      end else begin
        ext_in_valid = 1'b0;
        ext_in_data  = 8'($urandom);
        if (gap_left > 0) gap_left--;
      end
      @(posedge clk);
      if (ext_in_valid) begin
        n++;
        idle     = 0;
        gap_left = $urandom_range(gap_max);
      end else begin
        idle++;
      end
      @(negedge clk);
      cyc++;
      flush        = 1'b0;
      ext_in_valid = 1'b0;
    end

    err     = (n < 4);
    exp_out = err ? NOP : (do_flush ? m_out : word);
    check("done_valid", 32'(instr_valid), 32'(!do_flush));
    check("done_err", 32'(fetch_err), 32'(err));
    check("done_data", instr_out, exp_out);
    check("done_busy", 32'(busy), 0);
    if (chk_lat) check("latency", 32'(cyc), 32'(AB + 5));
    if (!err) begin
      m_vld  = 1'b1;
      m_tag  = addr;
      m_data = word;
    end
    m_out = exp_out;

    if (do_inv) invalidate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    invalidate = 1'b0;
    if (do_inv) m_vld = 1'b0;
    check("pulse_valid", 32'(instr_valid), 0);
    check("pulse_err", 32'(fetch_err), 0);
  endtask

  // Idle cycle between requests, sometimes invalidating the cache
  task automatic idle_cycle();
    invalidate = ($urandom_range(9) == 0);
    pc_addr    = $urandom;
    @(posedge clk);
    @(negedge clk);
    if (invalidate) m_vld = 1'b0;
    invalidate = 1'b0;
    check("idle_valid", 32'(instr_valid), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    clr           = 1'b0;
    fetch_req     = 1'b0;
    flush         = 1'b0;
    invalidate    = 1'b0;
    pc_addr       = '0;
    ext_out_ready = 1'b0;
    ext_in_valid  = 1'b0;
    ext_in_data   = '0;
    m_vld         = 1'b0;
    m_tag         = '0;
    m_data        = '0;
    m_out         = NOP;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_instr", instr_out, NOP);
      check("rst_busy", 32'(busy), 0);
      check("rst_ovalid", 32'(ext_out_valid), 0);
      check("rst_ivalid", 32'(instr_valid), 0);
      check("rst_err", 32'(fetch_err), 0);
      fetch_req     = 1'($urandom);
      flush         = 1'($urandom);
      invalidate    = 1'($urandom);
      pc_addr       = $urandom;
      ext_out_ready = 1'($urandom);
      ext_in_valid  = 1'($urandom);
      ext_in_data   = 8'($urandom);
    end
    @(negedge clk);
    fetch_req     = 1'b0;
    flush         = 1'b0;
    invalidate    = 1'b0;
    ext_out_ready = 1'b0;
    ext_in_valid  = 1'b0;
    clr           = 1'b1;
    @(negedge clk);

    do_fetch(32'h0000_0000, $urandom, 100, 0, 2, 4, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0000_1234, 32'h0050_0513, 100, 0, 0, 4, 1'b0, 1'b0, 1'b1);
    do_fetch(32'h0000_1234, 32'h0, 100, 0, 0, 4, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0000_0020, $urandom, 100, 3, 0, 4, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0000_0300, $urandom, 100, 0, 1, 2, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0000_0300, $urandom, 100, 0, 1, 4, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0000_0400, $urandom, 100, 0, 1, 4, 1'b1, 1'b0, 1'b0);
    do_fetch(32'h0000_0400, $urandom, 100, 0, 1, 4, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0000_0500, $urandom, 100, 0, 0, 4, 1'b0, 1'b1, 1'b0);
    do_fetch(32'h0000_0500, $urandom, 100, 0, 0, 4, 1'b0, 1'b0, 1'b0);

    pc_addr   = 32'h0000_0600;
    fetch_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    check("mid_busy", 32'(busy), 1);
    ext_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ext_out_ready = 1'b0;
    clr = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ovalid", 32'(ext_out_valid), 0);
    check("mid_rst_instr", instr_out, NOP);
    check("mid_rst_ivalid", 32'(instr_valid), 0);
    @(negedge clk);
    clr   = 1'b1;
    m_vld = 1'b0;
    m_out = NOP;
    @(negedge clk);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      int          stop;
      bit          fl;
      bit          inv;
      a = 32'h100 + 32'(4 * $urandom_range(3));
      if ($urandom_range(4) == 0) a = $urandom;
      stop = ($urandom_range(11) == 0) ? int'($urandom_range(3)) : 4;
      fl   = (stop == 4) && ($urandom_range(5) == 0);
      inv  = ($urandom_range(7) == 0);
      do_fetch(a, $urandom, int'($urandom_range(100, 30)), int'($urandom_range(2)),
               int'($urandom_range(3)), stop, fl, inv, 1'b0);
      repeat ($urandom_range(2)) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_byte_fetch.md
Name: imem_byte_fetch

Overview:
- Instruction-fetch bridge directly upstream of the pipeline core's instruction input (INSTRUCTION_MEM_OUT).
- Takes the core's word-addressed PC and fetches the 32-bit instruction from an off-chip program memory over a byte-wide pin bus.
- Holds a one-entry last-fetch cache and drives a busy flag so the core stalls while a fetch is outstanding.

Parameters:
- ADDR_BYTES, 2: number of address bytes sent per fetch; the sent address is pc_addr[8*ADDR_BYTES-1:0].
- TIMEOUT_CYCLES, 255: idle cycles allowed between data bytes before the fetch is aborted.
- NOP_INSTR, 32'h00000013: instruction returned on timeout and at reset.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- pc_addr  in  32  word address from the program counter.
- fetch_req  in  1  core requests the instruction at pc_addr.
- flush  in  1  taken branch/jump; the result of the outstanding fetch is discarded.
- invalidate  in  1  clears the fetch cache (program reload).
- instr_out  out  32  fetched instruction; held until the next completion.
- instr_valid  out  1  one-cycle pulse; instr_out is valid for pc_addr as latched.
- busy  out  1  fetch in progress; the core must stall.
- fetch_err  out  1  one-cycle pulse when a fetch times out.
- ext_out_data  out  8  address byte to external memory.
- ext_out_valid  out  1  ext_out_data is valid.
- ext_out_ready  in  1  external side accepts the byte this cycle.
- ext_in_data  in  8  instruction byte from external memory.
- ext_in_valid  in  1  ext_in_data is valid; always accepted in RECV.

Behaviour:
- Reset (clr=0, async) sets:
  - state=IDLE; instr_out=NOP_INSTR.
  - instr_valid, busy, fetch_err, ext_out_valid = 0; ext_out_data = 0.
  - cache_vld=0; all counters 0; flush_pend=0.
- Reset asserted mid-fetch aborts immediately. The external side is expected to be reset by the same clr.
- IDLE, fetch_req=1:
  - Hit (cache_vld and pc_addr equals cache_tag, all 32 bits): next cycle instr_valid=1, instr_out=cache_data, busy stays 0, state stays IDLE. Latency 1.
  - Miss: latch pc_addr, busy=1 from next cycle, byte_cnt=0, go to SEND_ADDR.
  - fetch_req is ignored while busy; pc_addr changes mid-fetch are ignored.
- SEND_ADDR:
  - ext_out_valid=1; ext_out_data = address byte byte_cnt, MSB first.
  - Data is held stable while ext_out_ready=0.
  - On ready: byte_cnt+1. After byte ADDR_BYTES-1 is accepted: ext_out_valid=0, byte_cnt=0, timer=0, go to RECV.
  - There is no timeout in SEND_ADDR.
- RECV:
  - Each ext_in_valid stores the byte little-endian into instr[8*byte_cnt +: 8]; byte_cnt+1; timer=0.
  - Each cycle without ext_in_valid: timer+1.
  - After the 4th byte: go to DONE.
  - timer == TIMEOUT_CYCLES: go to ERR. A byte arriving in the same cycle wins and resets the timer.
- DONE (1 cycle):
  - cache_tag/cache_data/cache_vld updated.
  - instr_out updated and instr_valid=1, unless flush_pend (then instr_out holds, no pulse).
  - busy=0; flush_pend=0; next IDLE.
- ERR (1 cycle):
  - instr_out=NOP_INSTR; instr_valid=1 and fetch_err=1, except no instr_valid if flush_pend.
  - Cache not updated; busy=0; next IDLE.
- flush:
  - Never aborts the external transaction.
  - When busy: sets flush_pend.
  - In IDLE: cancels a hit response scheduled for the next cycle.
- invalidate: cache_vld=0 next cycle. When concurrent with DONE, invalidate wins (cache_vld=0, but instr_valid still issues).
- Minimum miss latency, req to instr_valid, with an always-ready, always-valid external side: ADDR_BYTES+4+1 cycles (7 at the default).
- Counters: byte_cnt is 2 bits in RECV and clog2(ADDR_BYTES)+1 bits in SEND_ADDR. The timer is sized to hold TIMEOUT_CYCLES with no wrap, saturating at TIMEOUT_CYCLES.

Decomposition:
- Shared package imem_fetch_pkg:
  - state encoding: IDLE, SEND_ADDR, RECV, DONE, ERR;
  - NOP_INSTR constant;
  - the byte-count width function.
- One sub-module, fetch_timeout_counter: clear, increment, saturating compare against TIMEOUT_CYCLES, expired output. It is reusable for a future data-RAM bridge.

Test Plan:
- Reset: hold clr=0 with random inputs -> instr_out=32'h00000013, busy=0, ext_out_valid=0, instr_valid=0; release, then a request to 0 must miss.
- Miss: pc_addr=32'h00001234, ready=1, in-bytes 13,05,50,00 -> ext_out 12 then 34, instr_out=32'h00500513, instr_valid exactly 7 cycles after req, busy high for 6 cycles.
- Hit and backpressure:
  - Re-request 32'h00001234 -> instr_valid next cycle, ext_out_valid never asserted.
  - New miss 32'h00000020 with ready low for 3 cycles on the first byte -> ext_out_data=8'h00 stable for 4 cycles.
- Timeout: miss, then 2 bytes followed by silence -> after 255 idle cycles: fetch_err=1, instr_valid=1, instr_out=NOP; repeat request misses again.
- Flush and invalidate:
  - flush during RECV -> no instr_valid, busy drops at completion, following request to the same address hits.
  - invalidate coincident with DONE -> valid pulse issued, next request misses.
